// File: rtl/mvm_pkg.sv
// Shared widths and types for the MVM core and its weight/result feeder.
// The address helper keeps tile/word address arithmetic identical everywhere.
package mvm_pkg;

  localparam int N         = 4;
  localparam int DW        = 4;
  localparam int WW        = 4;
  localparam int NCOL      = 4;
  localparam int AW        = 8;
  localparam int TILEW     = 8;
  localparam int TIMEOUT   = 64;
  localparam int NCOL_LOG2 = $clog2(NCOL);

  typedef logic [DW-1:0] act_t;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    START,
    STREAM,
    WAIT,
    EMIT
  } feeder_state_e;

  // NCOL is a power of two, so the tile offset is a shift; the sum wraps modulo 2^AW.
  function automatic logic [AW-1:0] word_addr(input logic [AW-1:0]        base,
                                              input logic [TILEW-1:0]     tile,
                                              input logic [NCOL_LOG2-1:0] word);
    logic [AW-1:0] tile_off;
    tile_off = AW'(tile) << NCOL_LOG2;
    return base + tile_off + AW'(word);
  endfunction

endpackage

// File: rtl/mvm_feeder.sv
// Feeds the MVM core: fetches NCOL weight words per tile from a sync ROM, pulses start,
// waits for the core to finish, and hands each tile result downstream with valid/ready.
module mvm_feeder
  import mvm_pkg::*;
(
  input  logic              i_clk_feed,
  input  logic              i_rst_feed,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [AW-1:0]     i_req_base,
  input  logic [TILEW-1:0]  i_req_tiles,
  output logic              o_rom_en,
  output logic [AW-1:0]     o_rom_addr,
  input  logic [WW-1:0]     i_rom_data,
  output logic              o_start_mvm,
  output logic [WW-1:0]     o_w_mvm,
  input  logic              i_ismvm,
  input  logic [N*DW-1:0]   i_wx_result,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [N*DW-1:0]   o_res_data,
  output logic              o_res_last,
  output logic              o_busy,
  output logic              o_err_timeout
);

  localparam int CW = $clog2(TIMEOUT);

  feeder_state_e        state;
  logic [AW-1:0]        base;
  logic [TILEW-1:0]     tiles;
  logic [TILEW-1:0]     tile;
  logic [NCOL_LOG2-1:0] word;
  logic [CW-1:0]        cyc;
  logic                 rd_valid;
  logic                 seen_busy;

  // All outputs are registered; the ROM issue sequencer runs alongside PRIME/START/STREAM.
  always_ff @(posedge i_clk_feed or posedge i_rst_feed) begin
    if (i_rst_feed) begin
      state         <= IDLE;
      base          <= '0;
      tiles         <= '0;
      tile          <= '0;
      word          <= '0;
      cyc           <= '0;
      rd_valid      <= 1'b0;
      seen_busy     <= 1'b0;
      o_req_ready   <= 1'b1;
      o_rom_en      <= 1'b0;
      o_rom_addr    <= '0;
      o_start_mvm   <= 1'b0;
      o_w_mvm       <= '0;
      o_res_valid   <= 1'b0;
      o_res_data    <= '0;
      o_res_last    <= 1'b0;
      o_busy        <= 1'b0;
      o_err_timeout <= 1'b0;
    end else begin
      rd_valid    <= o_rom_en;
      o_w_mvm     <= rd_valid ? i_rom_data : '0;
      o_start_mvm <= 1'b0;

      if (o_rom_en) begin
        if (word == NCOL_LOG2'(NCOL-1)) begin
          o_rom_en <= 1'b0;
        end else begin
          word       <= word + 1'b1;
          o_rom_addr <= word_addr(base, tile, word + 1'b1);
        end
      end

      case (state)
        IDLE: begin
          if (i_req_valid && o_req_ready) begin
            base          <= i_req_base;
            tiles         <= i_req_tiles;
            tile          <= '0;
            o_err_timeout <= 1'b0;
            if (i_req_tiles != '0) begin
              state       <= PRIME;
              o_req_ready <= 1'b0;
              o_busy      <= 1'b1;
              o_rom_en    <= 1'b1;
              word        <= '0;
              o_rom_addr  <= word_addr(i_req_base, '0, '0);
              seen_busy   <= 1'b0;
            end
          end
        end
        PRIME: begin
          state       <= START;
          o_start_mvm <= 1'b1;
        end
        START: begin
          state <= STREAM;
          cyc   <= '0;
          if (i_ismvm) seen_busy <= 1'b1;
        end
        STREAM: begin
          if (i_ismvm) seen_busy <= 1'b1;
          if (cyc == CW'(NCOL-1)) begin
            state <= WAIT;
            cyc   <= '0;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        WAIT: begin
          if (seen_busy && !i_ismvm) begin
            o_res_data  <= i_wx_result;
            o_res_last  <= (tile == tiles - 1'b1);
            o_res_valid <= 1'b1;
            state       <= EMIT;
          end else begin
            if (i_ismvm) seen_busy <= 1'b1;
            // A core that never finishes aborts the rest of the job.
            if (cyc == CW'(TIMEOUT-1)) begin
              o_err_timeout <= 1'b1;
              state         <= IDLE;
              o_req_ready   <= 1'b1;
              o_busy        <= 1'b0;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
        end
        EMIT: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            if (o_res_last) begin
              state       <= IDLE;
              o_req_ready <= 1'b1;
              o_busy      <= 1'b0;
            end else begin
              tile       <= tile + 1'b1;
              state      <= PRIME;
              o_rom_en   <= 1'b1;
              word       <= '0;
              o_rom_addr <= word_addr(base, tile + 1'b1, '0);
              seen_busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_feeder.sv
// Directed bench for mvm_feeder with a sync ROM (ROM[a] = a[3:0]) and a simple MVM model
// that stays busy 3 cycles after each start and returns {4{start count}} as its result.
module tb_mvm_feeder;
  import mvm_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [AW-1:0]     req_base = '0;
  logic [TILEW-1:0]  req_tiles = '0;
  logic              rom_en;
  logic [AW-1:0]     rom_addr;
  logic [WW-1:0]     rom_data = '0;
  logic              start_mvm;
  logic [WW-1:0]     w_mvm;
  logic              ismvm;
  logic [N*DW-1:0]   wx_result;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [N*DW-1:0]   res_data;
  logic              res_last;
  logic              busy;
  logic              err_timeout;

  int compared = 0;
  int mismatched = 0;

  logic [AW-1:0] addr_log[$];
  int            start_count = 0;
  int            valid_cycles = 0;
  int            busy_cnt = 0;
  logic          mvm_dead = 1'b0;

  mvm_feeder dut (
    .i_clk_feed    (clk),
    .i_rst_feed    (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_base    (req_base),
    .i_req_tiles   (req_tiles),
    .o_rom_en      (rom_en),
    .o_rom_addr    (rom_addr),
    .i_rom_data    (rom_data),
    .o_start_mvm   (start_mvm),
    .o_w_mvm       (w_mvm),
    .i_ismvm       (ismvm),
    .i_wx_result   (wx_result),
    .o_res_valid   (res_valid),
    .i_res_ready   (res_ready),
    .o_res_data    (res_data),
    .o_res_last    (res_last),
    .o_busy        (busy),
    .o_err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // ROM, MVM model and event logging
  always @(posedge clk) begin
    if (rom_en) begin
      rom_data <= rom_addr[WW-1:0];
      addr_log.push_back(rom_addr);
    end
    if (start_mvm) begin
      start_count <= start_count + 1;
      busy_cnt    <= mvm_dead ? 0 : 3;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (res_valid) valid_cycles <= valid_cycles + 1;
  end

  assign ismvm     = (busy_cnt != 0);
  assign wx_result = {4{start_count[3:0]}};

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] base, input logic [TILEW-1:0] tiles);
    req_valid = 1'b1;
    req_base  = base;
    req_tiles = tiles;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic waitValid(input int maxc, output int ok);
    ok = int'(res_valid);
    for (int i = 0; i < maxc && ok == 0; i++) begin
      tick();
      ok = int'(res_valid);
    end
  endtask

  initial begin
    int ok;
    int s0;
    int sc;
    int vc;
    int n;
    logic [7:0] exp3 [4];

    exp3 = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    tick();
    tick();
    checkOutput("rst_req_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_rom_en", 32'(rom_en), 32'h0);
    checkOutput("rst_start", 32'(start_mvm), 32'h0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'h0);
    checkOutput("rst_err", 32'(err_timeout), 32'h0);
    rst = 1'b0;
    tick();

    // Single tile job from 0x10
    applyStimulus(8'h10, 8'd1);
    checkOutput("t1_prime_rom_en", 32'(rom_en), 32'h1);
    checkOutput("t1_prime_addr", 32'(rom_addr), 32'h10);
    checkOutput("t1_prime_req_ready", 32'(req_ready), 32'h0);
    checkOutput("t1_prime_busy", 32'(busy), 32'h1);
    tick();
    checkOutput("t1_start_pulse", 32'(start_mvm), 32'h1);
    checkOutput("t1_start_addr", 32'(rom_addr), 32'h11);
    for (int j = 0; j < 4; j++) begin
      tick();
      checkOutput($sformatf("t1_w_mvm_%0d", j), 32'(w_mvm), 32'(j));
    end
    tick();
    checkOutput("t1_w_mvm_after", 32'(w_mvm), 32'h0);
    checkOutput("t1_rom_en_after", 32'(rom_en), 32'h0);
    waitValid(20, ok);
    checkOutput("t1_res_valid_seen", 32'(ok), 32'h1);
    checkOutput("t1_res_data", 32'(res_data), 32'h1111);
    checkOutput("t1_res_last", 32'(res_last), 32'h1);
    tick();
    checkOutput("t1_res_valid_drop", 32'(res_valid), 32'h0);
    checkOutput("t1_idle_ready", 32'(req_ready), 32'h1);
    checkOutput("t1_idle_busy", 32'(busy), 32'h0);
    checkOutput("t1_start_count", 32'(start_count), 32'd1);

    // Three tiles with backpressure on tile 1
    res_ready = 1'b0;
    s0 = addr_log.size();
    applyStimulus(8'h10, 8'd3);
    waitValid(40, ok);
    checkOutput("t2_tile0_seen", 32'(ok), 32'h1);
    checkOutput("t2_tile0_data", 32'(res_data), 32'h2222);
    checkOutput("t2_tile0_last", 32'(res_last), 32'h0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("t2_tile0_drop", 32'(res_valid), 32'h0);
    waitValid(40, ok);
    checkOutput("t2_tile1_seen", 32'(ok), 32'h1);
    checkOutput("t2_tile1_data", 32'(res_data), 32'h3333);
    checkOutput("t2_tile1_last", 32'(res_last), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("t2_hold_valid_%0d", k), 32'(res_valid), 32'h1);
      checkOutput($sformatf("t2_hold_data_%0d", k), 32'(res_data), 32'h3333);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("t2_tile1_drop", 32'(res_valid), 32'h0);
    waitValid(40, ok);
    checkOutput("t2_tile2_seen", 32'(ok), 32'h1);
    checkOutput("t2_tile2_data", 32'(res_data), 32'h4444);
    checkOutput("t2_tile2_last", 32'(res_last), 32'h1);
    res_ready = 1'b1;
    tick();
    checkOutput("t2_idle_ready", 32'(req_ready), 32'h1);
    checkOutput("t2_addr_count", 32'(addr_log.size() - s0), 32'd12);
    for (int k = 0; k < 12; k++) begin
      logic [7:0] e;
      e = 8'h10 + 8'(k);
      checkOutput($sformatf("t2_addr_%0d", k), 32'(addr_log[s0+k]), 32'(e));
    end

    // Address wrap at the top of the ROM
    s0 = addr_log.size();
    applyStimulus(8'hFE, 8'd1);
    waitValid(40, ok);
    checkOutput("t3_seen", 32'(ok), 32'h1);
    checkOutput("t3_data", 32'(res_data), 32'h5555);
    checkOutput("t3_last", 32'(res_last), 32'h1);
    tick();
    checkOutput("t3_addr_count", 32'(addr_log.size() - s0), 32'd4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t3_addr_%0d", k), 32'(addr_log[s0+k]), 32'(exp3[k]));

    // Core never reports busy: timeout after 64 WAIT cycles, remaining tile dropped
    mvm_dead = 1'b1;
    sc = start_count;
    vc = valid_cycles;
    applyStimulus(8'h20, 8'd2);
    n = 0;
    while (!err_timeout && n < 200) begin
      tick();
      n++;
    end
    checkOutput("t4_timeout_cycles", 32'(n), 32'd70);
    checkOutput("t4_err", 32'(err_timeout), 32'h1);
    checkOutput("t4_idle_ready", 32'(req_ready), 32'h1);
    checkOutput("t4_idle_busy", 32'(busy), 32'h0);
    checkOutput("t4_starts", 32'(start_count - sc), 32'd1);
    checkOutput("t4_no_result", 32'(valid_cycles - vc), 32'd0);
    mvm_dead = 1'b0;
    tick();
    checkOutput("t4_err_sticky", 32'(err_timeout), 32'h1);

    // Zero-tile job: accepted, clears the error, no activity
    s0 = addr_log.size();
    sc = start_count;
    applyStimulus(8'h30, 8'd0);
    checkOutput("t5_err_cleared", 32'(err_timeout), 32'h0);
    checkOutput("t5_ready", 32'(req_ready), 32'h1);
    checkOutput("t5_busy", 32'(busy), 32'h0);
    repeat (5) tick();
    checkOutput("t5_no_rom", 32'(addr_log.size() - s0), 32'd0);
    checkOutput("t5_no_start", 32'(start_count - sc), 32'd0);
    checkOutput("t5_ready_after", 32'(req_ready), 32'h1);

    // Reset in the middle of streaming tile 1
    res_ready = 1'b1;
    applyStimulus(8'h10, 8'd2);
    waitValid(40, ok);
    checkOutput("t6_tile0_seen", 32'(ok), 32'h1);
    checkOutput("t6_tile0_data", 32'(res_data), 32'h7777);
    tick();
    vc = valid_cycles;
    n = 0;
    while (!start_mvm && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t6_tile1_start", 32'(start_mvm), 32'h1);
    tick();
    tick();
    checkOutput("t6_stream_w_mvm", 32'(w_mvm), 32'h5);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_rom_en", 32'(rom_en), 32'h0);
    checkOutput("t6_rst_w_mvm", 32'(w_mvm), 32'h0);
    checkOutput("t6_rst_busy", 32'(busy), 32'h0);
    checkOutput("t6_rst_ready", 32'(req_ready), 32'h1);
    checkOutput("t6_rst_addr", 32'(rom_addr), 32'h0);
    checkOutput("t6_rst_valid", 32'(res_valid), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    repeat (20) tick();
    checkOutput("t6_no_result", 32'(valid_cycles - vc), 32'd0);
    checkOutput("t6_idle_ready", 32'(req_ready), 32'h1);
    checkOutput("t6_idle_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
